// File: rtl/i2c_sensor_seq.sv
// Command sequencer for an I2C sensor: optional control-register write, conversion wait,
// then a register-addressed burst read, driving a byte-level I2C master through handshakes.
module i2c_sensor_seq #(
   parameter logic [6:0]  DEV_ADDR  = 7'h77,
   parameter int unsigned MAX_LEN   = 4,
   parameter logic [15:0] CONV_WAIT = 16'd5000,
   parameter logic [15:0] TIMEOUT   = 16'd20000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_ctrl_en,
   input  logic [7:0] cmd_ctrl_reg,
   input  logic [7:0] cmd_ctrl_val,
   input  logic [7:0] cmd_rd_reg,
   input  logic [3:0] cmd_len,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       done,
   output logic       error,
   output logic       start,
   output logic       stop,
   input  logic       ready,
   output logic       send,
   output logic [7:0] datasend,
   input  logic       sended,
   output logic       receive,
   output logic       rx_last,
   input  logic [7:0] datareceive,
   input  logic       received,
   input  logic       nack
);

   localparam logic [3:0] MAX_LEN_4 = 4'(MAX_LEN);

   typedef enum logic [3:0] {
      IDLE, WSTART, WADDR, WREG, WVAL, WSTOP, CONV, RSTART,
      RADDRW, RREG, RRESTART, RADDRR, RDATA, RSTOP, FIN, ERR
   } state_e;

   state_e      state_q, state_d, send_next;
   logic [7:0]  ctrl_reg_q, ctrl_reg_d, ctrl_val_q, ctrl_val_d, rd_reg_q, rd_reg_d;
   logic [3:0]  len_q, len_d, idx_q, idx_d;
   logic [15:0] wdog_q, wdog_d;
   logic        started_q, started_d, stop_sent_q, stop_sent_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        timed_out, wdog_rst;

   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the edge only; a mid-command reset simply drops the state, so no stop or error strobe is generated.
      if (reset) begin
         state_q     <= IDLE;
         ctrl_reg_q  <= '0;
         ctrl_val_q  <= '0;
         rd_reg_q    <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         wdog_q      <= '0;
         started_q   <= 1'b0;
         stop_sent_q <= 1'b0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ctrl_reg_q  <= ctrl_reg_d;
         ctrl_val_q  <= ctrl_val_d;
         rd_reg_q    <= rd_reg_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         wdog_q      <= wdog_d;
         started_q   <= started_d;
         stop_sent_q <= stop_sent_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default here so no path through the case can infer a latch.
      state_d     = state_q;
      send_next   = IDLE;
      ctrl_reg_d  = ctrl_reg_q;
      ctrl_val_d  = ctrl_val_q;
      rd_reg_d    = rd_reg_q;
      len_d       = len_q;
      idx_d       = idx_q;
      started_d   = started_q;
      stop_sent_d = stop_sent_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      wdog_rst    = 1'b0;
      timed_out   = (wdog_q == TIMEOUT - 16'd1);
      cmd_ready   = 1'b0;
      start       = 1'b0;
      stop        = 1'b0;
      send        = 1'b0;
      datasend    = '0;
      receive     = 1'b0;
      rx_last     = 1'b0;
      done        = 1'b0;
      error       = 1'b0;

      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               ctrl_reg_d = cmd_ctrl_reg;
               ctrl_val_d = cmd_ctrl_val;
               rd_reg_d   = cmd_rd_reg;
               len_d      = cmd_len;
               idx_d      = '0;
               started_d  = 1'b0;
               if (cmd_len == 4'd0 || cmd_len > MAX_LEN_4) state_d = ERR;
               else if (cmd_ctrl_en)                        state_d = WSTART;
               else                                         state_d = RSTART;
            end
         end
         WSTART, RSTART, RRESTART: begin
            if (ready) begin
               start     = 1'b1;
               started_d = 1'b1;
               if (state_q == WSTART)      state_d = WADDR;
               else if (state_q == RSTART) state_d = RADDRW;
               else                        state_d = RADDRR;
            end else if (timed_out) begin
               state_d = ERR;
            end
         end
         WADDR, WREG, WVAL, RADDRW, RREG, RADDRR: begin
            send = 1'b1;
            case (state_q)
               WADDR:   begin datasend = {DEV_ADDR, 1'b0}; send_next = WREG;     end
               WREG:    begin datasend = ctrl_reg_q;       send_next = WVAL;     end
               WVAL:    begin datasend = ctrl_val_q;       send_next = WSTOP;    end
               RADDRW:  begin datasend = {DEV_ADDR, 1'b0}; send_next = RREG;     end
               RREG:    begin datasend = rd_reg_q;         send_next = RRESTART; end
               default: begin datasend = {DEV_ADDR, 1'b1}; send_next = RDATA;    end
            endcase
            if (sended)                 state_d = send_next;
            else if (nack || timed_out) state_d = ERR;
         end
         RDATA: begin
            receive = 1'b1;
            rx_last = (idx_q == len_q - 4'd1);
            if (received) begin
               rd_valid_d = 1'b1;
               rd_data_d  = datareceive;
               wdog_rst   = 1'b1;
               if (rx_last) state_d = RSTOP;
               else         idx_d   = idx_q + 4'd1;
            end else if (timed_out) begin
               state_d = ERR;
            end
         end
         WSTOP, RSTOP: begin
            if (!stop_sent_q) begin
               stop        = 1'b1;
               stop_sent_d = 1'b1;
               started_d   = 1'b0;
            end else if (ready) begin
               state_d = (state_q == WSTOP) ? CONV : FIN;
            end else if (timed_out) begin
               state_d = ERR;
            end
         end
         CONV: begin
            if (wdog_q == CONV_WAIT - 16'd1) state_d = RSTART;
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         ERR: begin
            error     = 1'b1;
            stop      = started_q;
            started_d = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Watchdog and stop-issued flag are per state visit.
      if (state_d != state_q) begin
         wdog_rst    = 1'b1;
         stop_sent_d = 1'b0;
      end
      wdog_d = wdog_rst ? '0 : wdog_q + 16'd1;
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_i2c_sensor_seq.sv
// Directed bench for i2c_sensor_seq: behavioural byte-level I2C master plus scoreboards
// for transmitted bytes, rx_last flags and read data.
module tb_i2c_sensor_seq;

   localparam logic [6:0]  DEV = 7'h77;
   localparam int          MAXL = 4;
   localparam logic [15:0] CW  = 16'd20;
   localparam logic [15:0] TO  = 16'd60;
   localparam int          LAT = 2;

   logic       clk, reset;
   logic       cmd_valid, cmd_ready, cmd_ctrl_en;
   logic [7:0] cmd_ctrl_reg, cmd_ctrl_val, cmd_rd_reg;
   logic [3:0] cmd_len;
   logic [7:0] rd_data, datasend, datareceive;
   logic       rd_valid, done, error, start, stop, ready, send, sended;
   logic       receive, rx_last, received, nack;

   i2c_sensor_seq #(.DEV_ADDR(DEV), .MAX_LEN(MAXL), .CONV_WAIT(CW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ctrl_en(cmd_ctrl_en), .cmd_ctrl_reg(cmd_ctrl_reg), .cmd_ctrl_val(cmd_ctrl_val),
      .cmd_rd_reg(cmd_rd_reg), .cmd_len(cmd_len), .rd_data(rd_data), .rd_valid(rd_valid),
      .done(done), .error(error), .start(start), .stop(stop), .ready(ready), .send(send),
      .datasend(datasend), .sended(sended), .receive(receive), .rx_last(rx_last),
      .datareceive(datareceive), .received(received), .nack(nack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboards, filled by the stimulus and drained by the master model.
   logic [7:0] exp_tx[$], slave_q[$], exp_rd[$];
   logic       exp_last[$];

   bit   stall_send = 1'b0;
   int   nack_at = -1;
   int   byte_idx, lat = LAT, busy = 0, cyc = 0;
   int   start_cnt, stop_cnt, done_cnt, err_cnt, rdv_cnt, send_rises, overlap;
   int   send_rise_cyc, err_cyc, ready_rise = 0, starts_at_rd, stops_at_rd;
   int   start_gap[8];
   logic send_prev = 1'b0, was_ack;
   logic [31:0] exp_v;

   task automatic clear_counts();
      start_cnt = 0; stop_cnt = 0; done_cnt = 0; err_cnt = 0; rdv_cnt = 0;
      send_rises = 0; overlap = 0; byte_idx = 0; starts_at_rd = -1; stops_at_rd = -1;
      send_rise_cyc = 0; err_cyc = 0;
      for (int i = 0; i < 8; i++) start_gap[i] = -1;
   endtask

   task automatic flush();
      exp_tx.delete(); slave_q.delete(); exp_rd.delete(); exp_last.delete();
   endtask

   // Master model and monitor.
   always @(negedge clk) begin
      cyc++;
      was_ack  = sended | nack | received;
      sended   = 1'b0;
      nack     = 1'b0;
      received = 1'b0;
      if (start) begin
         if (start_cnt < 8) start_gap[start_cnt] = cyc - ready_rise;
         start_cnt++;
      end
      if (stop) begin
         stop_cnt++; busy = 3; ready = 1'b0;
      end else if (busy > 0) begin
         busy--;
         if (busy == 0) begin ready = 1'b1; ready_rise = cyc; end
      end
      if (send && !send_prev) begin send_rise_cyc = cyc; send_rises++; end
      send_prev = send;
      if (done) done_cnt++;
      if (error) begin err_cnt++; err_cyc = cyc; end
      if ((done && error) || (send && receive)) overlap++;
      if (rd_valid) begin
         rdv_cnt++;
         exp_v = (exp_rd.size() > 0) ? 32'(exp_rd.pop_front()) : 32'hDEAD;
         check("rd_data", 32'(rd_data), exp_v);
      end
      if (reset) begin
         lat = LAT;
      end else if (send && !was_ack && !stall_send) begin
         if (lat > 0) lat--;
         else begin
            lat = LAT;
            exp_v = (exp_tx.size() > 0) ? 32'(exp_tx.pop_front()) : 32'hDEAD;
            check("tx_byte", 32'(datasend), exp_v);
            if (datasend == {DEV, 1'b1}) begin
               starts_at_rd = start_cnt; stops_at_rd = stop_cnt;
            end
            if (byte_idx == nack_at) nack = 1'b1;
            else                     sended = 1'b1;
            byte_idx++;
         end
      end else if (receive && !was_ack) begin
         if (lat > 0) lat--;
         else begin
            lat = LAT;
            exp_v = (exp_last.size() > 0) ? 32'(exp_last.pop_front()) : 32'hDEAD;
            check("rx_last", 32'(rx_last), exp_v);
            datareceive = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
            received = 1'b1;
         end
      end
   end

   task automatic issue_cmd(input bit en, input logic [7:0] creg, input logic [7:0] cval,
                            input logic [7:0] rreg, input logic [3:0] len, input int hold);
      int n;
      n = 0;
      while (!cmd_ready && n < 500) begin @(negedge clk); #1; n++; end
      check("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
      cmd_ctrl_en = en; cmd_ctrl_reg = creg; cmd_ctrl_val = cval;
      cmd_rd_reg = rreg; cmd_len = len; cmd_valid = 1'b1;
      repeat (hold) begin @(negedge clk); #1; end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_end();
      int n;
      n = 0;
      while (done_cnt + err_cnt == 0 && n < 2000) begin @(negedge clk); #1; n++; end
      check("cmd_end_events", 32'(done_cnt + err_cnt), 32'd1);
      repeat (6) begin @(negedge clk); #1; end
   endtask

   initial begin
      int n;
      reset = 1'b1; cmd_valid = 1'b0; cmd_ctrl_en = 1'b0; cmd_ctrl_reg = '0;
      cmd_ctrl_val = '0; cmd_rd_reg = '0; cmd_len = '0; ready = 1'b1;
      sended = 1'b0; received = 1'b0; nack = 1'b0; datareceive = '0;
      clear_counts();
      repeat (3) begin @(negedge clk); #1; end
      check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      check("reset_strobes", 32'({start, stop, send, receive, rx_last, done, error, rd_valid}), 32'd0);
      check("reset_datasend", 32'(datasend), 32'd0);
      check("reset_rd_data", 32'(rd_data), 32'd0);
      reset = 1'b0;
      @(negedge clk); #1;

      // Control write, conversion wait, two-byte read; cmd_valid held into the busy phase.
      clear_counts();
      exp_tx = '{8'hEE, 8'hF4, 8'h2E, 8'hEE, 8'hF6, 8'hEF};
      slave_q = '{8'hA1, 8'hB2}; exp_rd = '{8'hA1, 8'hB2}; exp_last = '{1'b0, 1'b1};
      issue_cmd(1'b1, 8'hF4, 8'h2E, 8'hF6, 4'd2, 3);
      wait_end();
      check("t1_done", 32'(done_cnt), 32'd1);
      check("t1_error", 32'(err_cnt), 32'd0);
      check("t1_starts", 32'(start_cnt), 32'd3);
      check("t1_stops", 32'(stop_cnt), 32'd2);
      check("t1_rd_valid", 32'(rdv_cnt), 32'd2);
      check("t1_conv_gap", 32'(start_gap[1]), 32'(CW) + 32'd1);
      check("t1_starts_before_raddrr", 32'(starts_at_rd), 32'd3);
      check("t1_stops_before_raddrr", 32'(stops_at_rd), 32'd1);
      check("t1_tx_left", 32'(exp_tx.size()), 32'd0);
      check("t1_overlap", 32'(overlap), 32'd0);

      // Read only, single byte.
      clear_counts();
      exp_tx = '{8'hEE, 8'hD0, 8'hEF};
      slave_q = '{8'h55}; exp_rd = '{8'h55}; exp_last = '{1'b1};
      issue_cmd(1'b0, 8'h00, 8'h00, 8'hD0, 4'd1, 1);
      wait_end();
      check("t2_done", 32'(done_cnt), 32'd1);
      check("t2_starts", 32'(start_cnt), 32'd2);
      check("t2_stops", 32'(stop_cnt), 32'd1);
      check("t2_stops_before_raddrr", 32'(stops_at_rd), 32'd0);
      check("t2_rd_valid", 32'(rdv_cnt), 32'd1);
      check("t2_rd_data_hold", 32'(rd_data), 32'h55);

      // Slave NACKs the register byte.
      clear_counts(); flush();
      exp_tx = '{8'hEE, 8'h10};
      nack_at = 1;
      issue_cmd(1'b0, 8'h00, 8'h00, 8'h10, 4'd2, 1);
      wait_end();
      nack_at = -1;
      check("t3_error", 32'(err_cnt), 32'd1);
      check("t3_done", 32'(done_cnt), 32'd0);
      check("t3_stops", 32'(stop_cnt), 32'd1);
      check("t3_rd_valid", 32'(rdv_cnt), 32'd0);
      check("t3_cmd_ready_after", 32'(cmd_ready), 32'd1);

      // Illegal lengths: zero and MAX_LEN+1.
      for (int k = 0; k < 2; k++) begin
         clear_counts(); flush();
         issue_cmd(1'b1, 8'h01, 8'h02, 8'h03, (k == 0) ? 4'd0 : 4'(MAXL + 1), 1);
         wait_end();
         check("t4_error", 32'(err_cnt), 32'd1);
         check("t4_starts", 32'(start_cnt), 32'd0);
         check("t4_sends", 32'(send_rises), 32'd0);
         check("t4_stops", 32'(stop_cnt), 32'd0);
      end

      // Master never acknowledges the address byte.
      clear_counts(); flush();
      stall_send = 1'b1;
      issue_cmd(1'b1, 8'hF4, 8'h2E, 8'hF6, 4'd1, 1);
      wait_end();
      stall_send = 1'b0;
      check("t5_error", 32'(err_cnt), 32'd1);
      check("t5_timeout_latency", 32'(err_cyc - send_rise_cyc), 32'(TO));
      check("t5_stops", 32'(stop_cnt), 32'd1);

      // Reset while the read burst is in progress, then a normal command.
      clear_counts(); flush();
      exp_tx = '{8'hEE, 8'h20, 8'hEF};
      slave_q = '{8'h31, 8'h32, 8'h33}; exp_rd = '{8'h31, 8'h32, 8'h33};
      exp_last = '{1'b0, 1'b0, 1'b1};
      issue_cmd(1'b0, 8'h00, 8'h00, 8'h20, 4'd3, 1);
      n = 0;
      while (!(rdv_cnt == 1 && receive) && n < 500) begin @(negedge clk); #1; n++; end
      check("t6_in_rdata", 32'(rdv_cnt), 32'd1);
      reset = 1'b1;
      clear_counts();
      @(negedge clk); #1;
      check("t6_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("t6_rst_strobes", 32'({start, stop, send, receive, done, error, rd_valid}), 32'd0);
      reset = 1'b0;
      repeat (5) begin @(negedge clk); #1; end
      check("t6_no_stop", 32'(stop_cnt), 32'd0);
      check("t6_no_end", 32'(done_cnt + err_cnt), 32'd0);
      clear_counts(); flush();
      exp_tx = '{8'hEE, 8'h40, 8'hEF};
      slave_q = '{8'h77}; exp_rd = '{8'h77}; exp_last = '{1'b1};
      issue_cmd(1'b0, 8'h00, 8'h00, 8'h40, 4'd1, 1);
      wait_end();
      check("t6_after_done", 32'(done_cnt), 32'd1);
      check("t6_after_rd_valid", 32'(rdv_cnt), 32'd1);
      check("t6_overlap", 32'(overlap), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "bench did not finish");
   end

endmodule

// File: doc/i2c_sensor_seq.md
I2C_SENSOR_SEQ -- requirements
Module: i2c_sensor_seq

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h77, 7-bit I2C slave address.
REQ-002 SHALL have parameter MAX_LEN, default 4, max bytes per read burst (1..15).
REQ-003 SHALL have parameter CONV_WAIT, default 16'd5000, clk cycles between control write and read.
REQ-004 SHALL have parameter TIMEOUT, default 16'd20000, max clk cycles waiting any master handshake.
REQ-005 SHALL have ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  idle, command accepted when cmd_valid&cmd_ready
- cmd_ctrl_en  in  1  perform control write before read
- cmd_ctrl_reg  in  8  control register address
- cmd_ctrl_val  in  8  control value
- cmd_rd_reg  in  8  first register to read
- cmd_len  in  4  bytes to read
- rd_data  out  8  read byte
- rd_valid  out  1  one-cycle strobe per byte
- done  out  1  one-cycle strobe, command finished OK
- error  out  1  one-cycle strobe, command aborted
- start  out  1  one-cycle pulse: (re)start condition to master
- stop  out  1  one-cycle pulse: stop condition to master
- ready  in  1  master idle
- send  out  1  held high until sended
- datasend  out  8  byte to transmit, stable while send=1
- sended  in  1  one-cycle: byte transmitted and ACKed
- receive  out  1  held high until received
- rx_last  out  1  NACK this byte (last of burst), stable while receive=1
- datareceive  in  8  received byte, valid with received
- received  in  1  one-cycle: byte received
- nack  in  1  one-cycle: slave NACKed a sent byte

Function
REQ-006 SHALL implement states IDLE, WSTART, WADDR, WREG, WVAL, WSTOP, CONV, RSTART, RADDRW, RREG, RRESTART, RADDRR, RDATA, RSTOP, FIN, ERR.
REQ-007 IDLE: cmd_ready=1; on accept latch all cmd_* fields; go WSTART if cmd_ctrl_en else RSTART.
REQ-008 cmd_len=0 or cmd_len>MAX_LEN SHALL be accepted and completed via ERR without any master activity.
REQ-009 *START states SHALL wait ready=1, then pulse start once and advance next cycle.
REQ-010 WADDR/RADDRW SHALL send {DEV_ADDR,1'b0}; RADDRR SHALL send {DEV_ADDR,1'b1}; WREG sends ctrl_reg; WVAL sends ctrl_val; RREG sends rd_reg.
REQ-011 Send states SHALL hold send=1 and datasend constant until sended or nack; sended advances; nack goes ERR.
REQ-012 RRESTART SHALL pulse start without stop (repeated start) then go RADDRR.
REQ-013 RDATA SHALL hold receive=1 per byte; rx_last=1 iff byte index = len-1; on received drive rd_data=datareceive and rd_valid=1 same next cycle, increment index; after last byte go RSTOP.
REQ-014 WSTOP/RSTOP SHALL pulse stop once, then wait ready=1; WSTOP -> CONV, RSTOP -> FIN.
REQ-015 CONV SHALL count exactly CONV_WAIT cycles then go RSTART.
REQ-016 FIN SHALL pulse done for one cycle then IDLE; ERR SHALL pulse stop (if a start was issued this command) and error for one cycle, then IDLE.
REQ-017 Per-state watchdog SHALL reset on each state change; reaching TIMEOUT in any waiting state except CONV SHALL go ERR.
REQ-018 done and error SHALL never assert in the same cycle; send and receive SHALL never both be 1.
REQ-019 cmd_valid outside IDLE SHALL be ignored (no queueing).
REQ-020 Handshake inputs arriving in a state not expecting them SHALL be ignored.

Reset
REQ-021 reset SHALL force IDLE, clear counters; all outputs 0 except cmd_ready=1; datasend=rd_data=8'h00.
REQ-022 reset mid-transaction SHALL take effect next edge with no stop pulse; no done/error.

Verification
REQ-023 ctrl_en=1, reg F4/val 2E, rd_reg F6, len 2, master model ACKs -> datasend EE,F4,2E; stop; CONV_WAIT gap; EE,F6,start,EF; two rd_valid, rx_last on 2nd; one done.
REQ-024 ctrl_en=0, rd_reg D0, len 1, slave returns 55 -> no WSTOP/CONV, rd_data=55, rx_last=1, done.
REQ-025 nack during RREG -> stop pulse, error pulse, no rd_valid, cmd_ready=1 after.
REQ-026 len=0 and len=MAX_LEN+1 -> error pulse, start/send never asserted.
REQ-027 master never returns sended -> error exactly TIMEOUT cycles after send rose.
REQ-028 reset asserted during RDATA -> next cycle IDLE, all strobes 0, new command runs normally.
